// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared constants and types for the CONV host-side memory
//               responder: data/address widths, bank depths, layer-select
//               codes and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int DW       = 20;
  localparam int AW       = 12;
  localparam int L0_DEPTH = 4096;
  localparam int L1_DEPTH = 1024;

  localparam logic [2:0] CSEL_L0 = 3'b001;
  localparam logic [2:0] CSEL_L1 = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_RUN  = 3'd2,
    ST_DONE = 3'd3,
    ST_DUMP = 3'd4
  } conv_state_t;

  // Source of the word currently presented on the layer read port.
  typedef enum logic [1:0] {
    RB_ZERO = 2'd0,
    RB_L0   = 2'd1,
    RB_L1   = 2'd2
  } rd_bank_t;

endpackage
`default_nettype wire

// File: rtl/conv_dp_ram.sv
`default_nettype none
// ============================================================================
// Module      : conv_dp_ram
// Description : Simple dual-port RAM, one synchronous write port and one
//               synchronous read port. A read and a write to the same address
//               in one cycle returns the old contents. The read register
//               holds its value while rd_en is low and is cleared by reset;
//               the array itself is never reset.
// Ports       : clk, reset (async, active low)
//               wr_en / wr_addr / wr_data : write port
//               rd_en / rd_addr / rd_data : read port, 1-cycle latency
// Revision    : 1.0 - initial release
// ============================================================================
module conv_dp_ram #(
  parameter int DW    = 20,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Reads sample the pre-edge array, which gives read-before-write.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/conv_host_mem.sv
`default_nettype none
// ============================================================================
// Module      : conv_host_mem
// Description : Host-side responder for the CONV accelerator. Holds the
//               input image, hands it to the accelerator (ready/busy
//               handshake), owns the layer-0 and layer-1 result banks and
//               streams a selected bank back out after the run.
// Ports       : clk, reset (async, active low)
//               ld_valid/ld_addr/ld_data     : image preload (IDLE only)
//               start, ready, busy, done     : run control
//               iaddr/idata                  : image read, 1-cycle latency
//               cwr/caddr_wr/cdata_wr, csel  : layer write
//               crd/caddr_rd/cdata_rd        : layer read, 1-cycle latency
//               dump_start/dump_sel          : readout request (DONE only)
//               dump_valid/dump_addr/dump_data : readout stream
//               err                          : sticky protocol error
// Revision    : 1.0 - initial release
// ============================================================================
module conv_host_mem
  import conv_pkg::*;
#(
  parameter int DW          = conv_pkg::DW,
  parameter int AW          = conv_pkg::AW,
  parameter int L0_DEPTH    = conv_pkg::L0_DEPTH,
  parameter int L1_DEPTH    = conv_pkg::L1_DEPTH,
  parameter int ARM_TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  output logic          done,
  input  logic          dump_start,
  input  logic          dump_sel,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          err
);

  localparam int L0_AW = $clog2(L0_DEPTH);
  localparam int L1_AW = $clog2(L1_DEPTH);
  localparam int TCW   = $clog2(ARM_TIMEOUT + 1);

  localparam logic [AW-1:0]  L1_LIMIT = AW'(L1_DEPTH);
  localparam logic [AW-1:0]  L0_LAST  = AW'(L0_DEPTH - 1);
  localparam logic [AW-1:0]  L1_LAST  = AW'(L1_DEPTH - 1);
  localparam logic [TCW-1:0] ARM_LAST = TCW'(ARM_TIMEOUT - 1);

  conv_state_t   state_q,      state_d;
  logic [TCW-1:0] arm_cnt_q,   arm_cnt_d;
  logic [AW-1:0] dump_cnt_q,   dump_cnt_d;
  logic          dump_sel_q,   dump_sel_d;
  logic          dump_valid_q, dump_valid_d;
  logic [AW-1:0] dump_addr_q,  dump_addr_d;
  logic          done_q,       done_d;
  logic          err_q,        err_d;
  logic          rd_vld_q,     rd_vld_d;
  rd_bank_t      rd_bank_q,    rd_bank_d;
  logic [DW-1:0] cdata_hold_q, cdata_hold_d;

  logic          in_dump;
  logic          arm_timeout;
  logic          img_we;
  logic          l0_we, l1_we;
  logic          l0_host_re, l1_host_re;
  logic          l0_re, l1_re;
  logic [L0_AW-1:0] l0_ra;
  logic [L1_AW-1:0] l1_ra;
  logic [DW-1:0] l0_rdata, l1_rdata;
  logic [DW-1:0] rd_word;

  // --------------------------------------------------------------------------
  // Access decode
  // --------------------------------------------------------------------------
  assign in_dump    = (state_q == ST_DUMP);
  assign img_we     = ld_valid && (state_q == ST_IDLE);

  assign l0_we      = cwr && !in_dump && (csel == CSEL_L0);
  assign l1_we      = cwr && !in_dump && (csel == CSEL_L1) && (caddr_wr < L1_LIMIT);
  assign l0_host_re = crd && !in_dump && (csel == CSEL_L0);
  assign l1_host_re = crd && !in_dump && (csel == CSEL_L1) && (caddr_rd < L1_LIMIT);

  // During readout the bank read ports belong to the dump sequencer.
  assign l0_re = l0_host_re || (in_dump && !dump_sel_q);
  assign l1_re = l1_host_re || (in_dump &&  dump_sel_q);
  assign l0_ra = in_dump ? dump_cnt_q[L0_AW-1:0] : caddr_rd[L0_AW-1:0];
  assign l1_ra = in_dump ? dump_cnt_q[L1_AW-1:0] : caddr_rd[L1_AW-1:0];

  // --------------------------------------------------------------------------
  // Memories
  // --------------------------------------------------------------------------
  conv_dp_ram #(.DW(DW), .DEPTH(L0_DEPTH)) u_img_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (img_we),
    .wr_addr (ld_addr[L0_AW-1:0]),
    .wr_data (ld_data),
    .rd_en   (1'b1),
    .rd_addr (iaddr[L0_AW-1:0]),
    .rd_data (idata)
  );

  conv_dp_ram #(.DW(DW), .DEPTH(L0_DEPTH)) u_l0_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (l0_we),
    .wr_addr (caddr_wr[L0_AW-1:0]),
    .wr_data (cdata_wr),
    .rd_en   (l0_re),
    .rd_addr (l0_ra),
    .rd_data (l0_rdata)
  );

  conv_dp_ram #(.DW(DW), .DEPTH(L1_DEPTH)) u_l1_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (l1_we),
    .wr_addr (caddr_wr[L1_AW-1:0]),
    .wr_data (cdata_wr),
    .rd_en   (l1_re),
    .rd_addr (l1_ra),
    .rd_data (l1_rdata)
  );

  // --------------------------------------------------------------------------
  // Controller next-state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = '0;
    dump_cnt_d  = dump_cnt_q;
    dump_sel_d  = dump_sel_q;
    arm_timeout = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        // busy wins over a timeout landing in the same cycle.
        if (busy) begin
          state_d = ST_RUN;
        end else if (arm_cnt_q == ARM_LAST) begin
          arm_timeout = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          arm_cnt_d = arm_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!busy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (dump_start) begin
          state_d    = ST_DUMP;
          dump_cnt_d = '0;
          dump_sel_d = dump_sel;
        end else if (start) begin
          state_d = ST_ARM;
        end
      end
      ST_DUMP: begin
        if (dump_cnt_q == (dump_sel_q ? L1_LAST : L0_LAST)) begin
          state_d = ST_DONE;
        end else begin
          dump_cnt_d = dump_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / status next-state
  // --------------------------------------------------------------------------
  always_comb begin
    done_d       = (state_q == ST_RUN) && !busy;
    dump_valid_d = in_dump;
    dump_addr_d  = in_dump ? dump_cnt_q : '0;

    rd_vld_d  = crd && !in_dump;
    rd_bank_d = RB_ZERO;
    if (l0_host_re) begin
      rd_bank_d = RB_L0;
    end else if (l1_host_re) begin
      rd_bank_d = RB_L1;
    end

    err_d = err_q
          | (ld_valid && (state_q != ST_IDLE))
          | (cwr && !(l0_we || l1_we))
          | (crd && !(l0_host_re || l1_host_re))
          | arm_timeout;
  end

  // The bank read registers are shared with the dump sequencer, so the host
  // read port shows the bank output only in the cycle after an accepted crd
  // and otherwise replays the word it last presented.
  always_comb begin
    rd_word = '0;
    case (rd_bank_q)
      RB_L0:   rd_word = l0_rdata;
      RB_L1:   rd_word = l1_rdata;
      default: rd_word = '0;
    endcase
  end

  assign cdata_rd     = rd_vld_q ? rd_word : cdata_hold_q;
  assign cdata_hold_d = cdata_rd;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      arm_cnt_q    <= '0;
      dump_cnt_q   <= '0;
      dump_sel_q   <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_bank_q    <= RB_ZERO;
      cdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      arm_cnt_q    <= arm_cnt_d;
      dump_cnt_q   <= dump_cnt_d;
      dump_sel_q   <= dump_sel_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rd_vld_q     <= rd_vld_d;
      rd_bank_q    <= rd_bank_d;
      cdata_hold_q <= cdata_hold_d;
    end
  end

  assign ready      = (state_q == ST_ARM);
  assign done       = done_q;
  assign err        = err_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_valid_q ? (dump_sel_q ? l1_rdata : l0_rdata) : '0;

endmodule
`default_nettype wire

// File: tb/tb_conv_host_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_host_mem
// Description : Directed self-checking bench for conv_host_mem: reset state,
//               ARM timeout, image read, layer read/write incl. read-before-
//               write and dropped accesses, run handshake, L1 readout and
//               reset abort during readout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_host_mem;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [11:0] ld_addr;
  logic [19:0] ld_data;
  logic        start;
  logic        ready;
  logic        busy;
  logic [11:0] iaddr;
  logic [19:0] idata;
  logic        cwr;
  logic [11:0] caddr_wr;
  logic [19:0] cdata_wr;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic [2:0]  csel;
  logic        done;
  logic        dump_start;
  logic        dump_sel;
  logic        dump_valid;
  logic [11:0] dump_addr;
  logic [19:0] dump_data;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv_host_mem dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .start      (start),
    .ready      (ready),
    .busy       (busy),
    .iaddr      (iaddr),
    .idata      (idata),
    .cwr        (cwr),
    .caddr_wr   (caddr_wr),
    .cdata_wr   (cdata_wr),
    .crd        (crd),
    .caddr_rd   (caddr_rd),
    .cdata_rd   (cdata_rd),
    .csel       (csel),
    .done       (done),
    .dump_start (dump_start),
    .dump_sel   (dump_sel),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] l1_pat(input int i);
    int v;
    v = i * 7 + 3;
    return v[19:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},      32'(ready),      32'h0);
    check({tag, "_idata"},      32'(idata),      32'h0);
    check({tag, "_cdata_rd"},   32'(cdata_rd),   32'h0);
    check({tag, "_done"},       32'(done),       32'h0);
    check({tag, "_dump_valid"}, 32'(dump_valid), 32'h0);
    check({tag, "_dump_addr"},  32'(dump_addr),  32'h0);
    check({tag, "_dump_data"},  32'(dump_data),  32'h0);
    check({tag, "_err"},        32'(err),        32'h0);
    check({tag, "_state"},      32'(dut.state_q), 32'(ST_IDLE));
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int bad;

    reset = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; busy = 1'b0; iaddr = '0;
    cwr = 1'b0; caddr_wr = '0; cdata_wr = '0;
    crd = 1'b0; caddr_rd = '0; csel = 3'b000;
    dump_start = 1'b0; dump_sel = 1'b0;

    repeat (3) tick();
    check_all_zero("rst");
    reset = 1'b1;
    tick();

    // Preload image[i] = i.
    for (int i = 0; i < 4096; i++) begin
      ld_valid = 1'b1;
      ld_addr  = 12'(i);
      ld_data  = 20'(i);
      tick();
    end
    ld_valid = 1'b0;
    check("preload_err", 32'(err), 32'h0);

    // ARM timeout: ready stays high 1024 cycles, then err and back to IDLE.
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    while (ready && cnt < 2000) begin
      cnt++;
      tick();
    end
    check("arm_ready_cycles", 32'(cnt), 32'd1024);
    check("arm_timeout_err", 32'(err), 32'h1);
    check("arm_timeout_state", 32'(dut.state_q), 32'(ST_IDLE));

    reset_pulse();
    check("rst2_err", 32'(err), 32'h0);

    // Write with an illegal select sets err.
    csel = 3'b010; cwr = 1'b1; caddr_wr = 12'h000; cdata_wr = 20'h00BAD;
    tick();
    cwr = 1'b0;
    check("bad_csel_wr_err", 32'(err), 32'h1);
    reset_pulse();

    // Run: ready, image read, busy handshake.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_rise", 32'(ready), 32'h1);
    iaddr = 12'h041;
    tick();
    check("idata_041", 32'(idata), 32'h00041);
    iaddr = 12'hFFF;
    tick();
    check("idata_fff", 32'(idata), 32'h00FFF);
    busy = 1'b1;
    tick();
    check("ready_drop", 32'(ready), 32'h0);

    // L0 write, read, read-before-write, hold.
    csel = 3'b001; cwr = 1'b1; caddr_wr = 12'h0FF; cdata_wr = 20'h12345;
    tick();
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h0FF;
    tick();
    crd = 1'b0;
    check("l0_rd", 32'(cdata_rd), 32'h12345);
    cwr = 1'b1; cdata_wr = 20'h54321; crd = 1'b1;
    tick();
    cwr = 1'b0; crd = 1'b0;
    check("l0_rbw", 32'(cdata_rd), 32'h12345);
    crd = 1'b1;
    tick();
    crd = 1'b0;
    check("l0_rd_new", 32'(cdata_rd), 32'h54321);
    tick();
    check("l0_rd_hold", 32'(cdata_rd), 32'h54321);
    check("run_err", 32'(err), 32'h0);

    // Fill L1.
    csel = 3'b011;
    for (int i = 0; i < 1024; i++) begin
      cwr = 1'b1; caddr_wr = 12'(i); cdata_wr = l1_pat(i);
      tick();
    end
    cwr = 1'b0;
    crd = 1'b1; caddr_rd = 12'd0;
    tick();
    caddr_rd = 12'd1023;
    check("l1_rd0", 32'(cdata_rd), 32'(l1_pat(0)));
    tick();
    crd = 1'b0;
    check("l1_rd1023", 32'(cdata_rd), 32'(l1_pat(1023)));
    check("l1_fill_err", 32'(err), 32'h0);

    // Dropped writes: L1 out of range, then illegal select.
    cwr = 1'b1; caddr_wr = 12'd1024; cdata_wr = 20'h0DEAD;
    tick();
    check("l1_oob_err", 32'(err), 32'h1);
    csel = 3'b010; caddr_wr = 12'd0; cdata_wr = 20'h0BEEF;
    tick();
    cwr = 1'b0;
    csel = 3'b011; crd = 1'b1; caddr_rd = 12'd0;
    tick();
    crd = 1'b0;
    check("l1_rd0_after_drop", 32'(cdata_rd), 32'(l1_pat(0)));
    csel = 3'b010; crd = 1'b1;
    tick();
    crd = 1'b0;
    check("bad_csel_rd", 32'(cdata_rd), 32'h0);

    // Drop busy: one-cycle done.
    busy = 1'b0;
    tick();
    check("done_pulse", 32'(done), 32'h1);
    check("done_state", 32'(dut.state_q), 32'(ST_DONE));
    tick();
    check("done_low", 32'(done), 32'h0);

    // L1 readout.
    dump_sel = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("dump_lat1", 32'(dump_valid), 32'h0);
    tick();
    check("dump_lat2", 32'(dump_valid), 32'h1);
    cnt = 0;
    bad = 0;
    while (dump_valid && cnt < 1100) begin
      if (dump_addr !== 12'(cnt) || dump_data !== l1_pat(cnt)) bad++;
      cnt++;
      tick();
    end
    check("dump_len", 32'(cnt), 32'd1024);
    check("dump_words_bad", 32'(bad), 32'd0);
    check("dump_end_state", 32'(dut.state_q), 32'(ST_DONE));
    check("dump_cdata_hold", 32'(cdata_rd), 32'h0);

    // Reset in the middle of an L0 readout.
    dump_sel = 1'b0; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (11) tick();
    check("mid_dump_valid", 32'(dump_valid), 32'h1);
    check("mid_dump_addr", 32'(dump_addr), 32'd10);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    reset = 1'b1;
    iaddr = 12'h123;
    tick();
    check("img_after_rst", 32'(idata), 32'h00123);

    // dump_start outside DONE is ignored.
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    tick();
    check("dump_ignored", 32'(dump_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_host_mem.md
# conv_host_mem

Host-side responder for the CONV accelerator interface. It holds the 64x64 input image, raises `ready`, and serves `idata` for each `iaddr`. It owns the layer-0 (4096-word) and layer-1 (1024-word) result memories selected by `csel`, serving both write and read accesses. After the accelerator drops `busy`, it streams either layer back out to the system for checking or transfer.

## Interface
Parameters:
- `DW`, 20, data width of image and layer words
- `AW`, 12, address width
- `L0_DEPTH`, 4096, layer-0 words
- `L1_DEPTH`, 1024, layer-1 words
- `ARM_TIMEOUT`, 1024, max cycles `ready` stays high without `busy`

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `ld_valid`  in  1  image preload write strobe
- `ld_addr`  in  12  image preload address
- `ld_data`  in  20  image preload data
- `start`  in  1  request one accelerator run
- `ready`  out  1  to accelerator: image available
- `busy`  in  1  from accelerator: run in progress
- `iaddr`  in  12  image read address
- `idata`  out  20  image read data
- `cwr`  in  1  layer write strobe
- `caddr_wr`  in  12  layer write address
- `cdata_wr`  in  20  layer write data
- `crd`  in  1  layer read strobe
- `caddr_rd`  in  12  layer read address
- `cdata_rd`  out  20  layer read data
- `csel`  in  3  layer select: 3'b001 = L0, 3'b011 = L1
- `done`  out  1  one-cycle pulse when the run completes
- `dump_start`  in  1  start readout; accepted in DONE only
- `dump_sel`  in  1  0 = L0, 1 = L1
- `dump_valid`  out  1  readout word valid
- `dump_addr`  out  12  readout word address
- `dump_data`  out  20  readout word data
- `err`  out  1  sticky protocol error flag

## Operation
- FSM states: IDLE, ARM, RUN, DONE, DUMP.
- IDLE:
  - `ld_valid` writes `ld_data` to image[`ld_addr`].
  - `start` moves the FSM to ARM.
- ARM:
  - `ready`=1.
  - `busy`=1 sampled → RUN, and `ready` drops the same edge.
  - The timeout counter reaches `ARM_TIMEOUT` → set `err`, go to IDLE.
- RUN:
  - `busy`=0 sampled → DONE.
  - `done` pulses for one cycle on entry to DONE.
- DONE:
  - `dump_start` → DUMP. The readout covers `dump_sel` depth (4096 or 1024 words), addresses 0..depth-1, ascending.
  - `start` → ARM. This starts a new run; layer contents are kept.
- DUMP:
  - Returns to DONE after the last word.
- Image read (all states): `idata` is registered from image[`iaddr`].
- Layer write (any state except DUMP):
  - On `cwr`=1, `cdata_wr` is written to the bank chosen by `csel`.
  - L1 addresses ≥1024 are dropped and set `err`.
  - Any other `csel` value drops the write and sets `err`.
- Layer read:
  - On `crd`=1, `cdata_rd` is registered from the selected bank.
  - An illegal `csel` or out-of-range L1 address returns 0 and sets `err`.
  - Without `crd`, `cdata_rd` holds its last value.
- Accesses that are ignored:
  - `ld_valid` outside IDLE: ignored, sets `err`.
  - `start` outside IDLE/DONE: ignored.
  - `dump_start` outside DONE: ignored.
  - `cwr`/`crd` during DUMP: ignored, sets `err`.
- `err` clears only on reset.

## Timing
- Reset values: `ready`=0, `idata`=0, `cdata_rd`=0, `done`=0, `dump_valid`=0, `dump_addr`=0, `dump_data`=0, `err`=0; FSM in IDLE.
- Reset does not clear memory contents. Reset mid-run or mid-dump aborts immediately.
- `idata` latency: 1 cycle. The value is valid the cycle after `iaddr` is presented.
- `cdata_rd` latency: 1 cycle after `crd`.
- `cwr` and `crd` in the same cycle to the same bank and address: read returns the old data (read-before-write).
- `cwr` and `crd` may both be active in every cycle.
- `ready` rises the cycle after `start` is accepted.
- `done` is asserted exactly one cycle after `busy`=0 is sampled in RUN.
- DUMP timing:
  - `dump_valid` first rises 2 cycles after `dump_start` (1 cycle for the address issue, 1 for RAM read latency).
  - It is then high for depth consecutive cycles.
  - `dump_addr` and `dump_data` are aligned with `dump_valid`.

## Structure
- Shared package `conv_pkg` holds:
  - `CSEL_L0` = 3'b001, `CSEL_L1` = 3'b011
  - `DW`, `AW`, `L0_DEPTH`, `L1_DEPTH`
  - FSM state typedef
- Sub-module `conv_dp_ram`: one synchronous write port and one synchronous read port, read-before-write, parameterised depth and width.
- `conv_dp_ram` instances:
  - Image: write = preload, read = `iaddr`.
  - L0 and L1: write = `cwr`; read = `crd`, muxed to the dump address during DUMP.

## Test plan
- Preload image[i] = i for all 4096 words; `start`; hold `busy`=0 → `ready`=1 for 1024 cycles, then `err`=1 and FSM back in IDLE.
- Preload; `start`; present `iaddr`=0x041 → `idata`=0x00041 next cycle; raise `busy` → `ready`=0 next cycle; drop `busy` → one-cycle `done` pulse.
- `cwr` with `csel`=001, addr 0x0FF, data 0x12345; next cycle `crd` at the same address → `cdata_rd`=0x12345 one cycle later. Same-cycle write of 0x54321 plus read at 0x0FF → read returns 0x12345.
- `cwr` with `csel`=011 at addr 1024, and `cwr` with `csel`=010 at addr 0 → both dropped, `err`=1. A subsequent L1 read at addr 0 returns its prior value.
- After `done`, `dump_start` with `dump_sel`=1 → 1024 consecutive `dump_valid` cycles with addresses 0..1023, data matching prior L1 writes, then FSM returns to DONE.
- Assert `reset`=0 mid-DUMP → all outputs 0 at once, FSM in IDLE; image contents still readable afterwards.
